// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the instruction-fetch stage.
package core_pkg;
   localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam int unsigned IMEM_DEPTH_DEF = 1024;

   typedef enum logic {RUN, FAULT} fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   // True when a byte address is misaligned or beyond the instruction memory.
   function automatic logic bad_pc(input logic [31:0] pc, input int unsigned depth);
      return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= depth);
   endfunction
endpackage

// File: rtl/pc_gen.sv
// pc_gen: next-PC selection (reset / redirect / hold / +4) with range and alignment check.
module pc_gen import core_pkg::*; #(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
   input  logic        rst_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        hold_i,
   input  logic [31:0] pc_i,
   output logic [31:0] next_pc_o,
   output logic        fault_o
);
   logic [31:0] seq_pc;

   always_comb begin
      seq_pc    = pc_i + 32'd4;
      next_pc_o = rst_i ? RESET_PC : redirect_valid_i ? redirect_pc_i : hold_i ? pc_i : seq_pc;
      // Only a redirect target or a sequential advance can raise a fault.
      fault_o   = ~rst_i & (redirect_valid_i ? bad_pc(redirect_pc_i, IMEM_DEPTH)
                                             : ~hold_i & bad_pc(seq_pc, IMEM_DEPTH));
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, the IF/ID register and the fetch counter.
module fetch_unit import core_pkg::*; #(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_rd_en_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_instr_o,
   output logic        if_id_valid_o,
   output logic        fetch_fault_o,
   output logic [31:0] fetch_count_o
);
   fetch_state_t state_q, state_d;
   if_id_t       if_id_q, if_id_d;
   logic [31:0]  pc_q, pc_d, count_q, count_d;
   logic         fault_q, fault_d, fault_next, advance;

   pc_gen #(.RESET_PC(RESET_PC), .IMEM_DEPTH(IMEM_DEPTH)) u_pc_gen (
      .rst_i           (rst),
      .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i   (redirect_pc_i),
      .hold_i          (state_q == FAULT || stall_i),
      .pc_i            (pc_q),
      .next_pc_o       (pc_d),
      .fault_o         (fault_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = fault_next ? FAULT : redirect_valid_i ? RUN : state_q;
   end

   always_comb begin
      imem_rd_en_o = (state_q == RUN) & ~stall_i & ~rst;
      advance      = imem_rd_en_o & ~redirect_valid_i;
   end

   // A flush or a faulted stage presents a NOP, keeping the last PC for visibility.
   always_comb begin
      if_id_d = (redirect_valid_i || state_q == FAULT) ? {if_id_q.pc, NOP_INSTR, 1'b0}
              : advance ? {pc_q, imem_instr_i, 1'b1} : if_id_q;
      fault_d = fault_q | fault_next;
      count_d = count_q + {31'b0, advance};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         if_id_q <= {RESET_PC, NOP_INSTR, 1'b0};
         fault_q <= 1'b0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   assign imem_addr_o   = {2'b00, pc_q[31:2]};
   assign if_id_pc_o    = if_id_q.pc;
   assign if_id_instr_o = if_id_q.instr;
   assign if_id_valid_o = if_id_q.valid;
   assign fetch_fault_o = fault_q;
   assign fetch_count_o = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model.
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, rv, rst1;
   logic [31:0] rpc;
   logic [31:0] addr0, instr0, ifpc0, ifins0, cnt0;
   logic        rd0, val0, flt0;
   logic [31:0] addr1, instr1, ifpc1, ifins1, cnt1;
   logic        rd1, val1, flt1;
   logic [31:0] mem [1024];
   int checks = 0, fails = 0;

   // Memory samples the address on the falling edge while read is enabled.
   always @(negedge clk) begin
      if (rd0) instr0 <= mem[addr0[9:0]];
      if (rd1) instr1 <= mem[addr1[9:0]];
   end

   fetch_unit u0 (
      .clk(clk), .rst(rst), .stall_i(stall), .redirect_valid_i(rv), .redirect_pc_i(rpc),
      .imem_addr_o(addr0), .imem_rd_en_o(rd0), .imem_instr_i(instr0),
      .if_id_pc_o(ifpc0), .if_id_instr_o(ifins0), .if_id_valid_o(val0),
      .fetch_fault_o(flt0), .fetch_count_o(cnt0)
   );

   fetch_unit #(.IMEM_DEPTH(4)) u1 (
      .clk(clk), .rst(rst1), .stall_i(1'b0), .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
      .imem_addr_o(addr1), .imem_rd_en_o(rd1), .imem_instr_i(instr1),
      .if_id_pc_o(ifpc1), .if_id_instr_o(ifins1), .if_id_valid_o(val1),
      .fetch_fault_o(flt1), .fetch_count_o(cnt1)
   );

   typedef struct {
      logic [31:0] pc, ipc, iins, cnt;
      bit          ival, flt, inf;
   } model_t;

   function automatic model_t step(model_t m, bit r, bit st, bit v, logic [31:0] p);
      model_t n = m;
      if (r) begin
         n.pc = 0; n.ipc = 0; n.iins = NOP; n.ival = 0; n.flt = 0; n.cnt = 0; n.inf = 0;
      end else if (v) begin
         n.ival = 0; n.iins = NOP; n.pc = p;
         n.inf = (p % 4 != 0) || (p / 4 >= 1024);
         if (n.inf) n.flt = 1;
      end else if (m.inf) begin
         n.ival = 0; n.iins = NOP;
      end else if (!st) begin
         n.ipc = m.pc; n.iins = mem[m.pc / 4]; n.ival = 1; n.cnt = m.cnt + 1;
         n.pc = m.pc + 4;
         if (n.pc / 4 >= 1024) begin n.inf = 1; n.flt = 1; end
      end
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; rv = 0; rpc = 0;
      tick(); tick();
      checks++; if (val0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", val0); end
      checks++; if (ifins0 !== NOP) begin fails++; $display("FAIL reset_instr got %h want %h", ifins0, NOP); end
      checks++; if ({flt0, cnt0, ifpc0} !== 65'h0) begin fails++; $display("FAIL reset_state got flt=%0b cnt=%0d pc=%h want 0", flt0, cnt0, ifpc0); end
      checks++; if (rd0 !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %0b want 0", rd0); end
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({ifpc0, ifins0, val0} !== {32'(i * 4), mem[i], 1'b1}) begin
            fails++; $display("FAIL seq_fetch%0d got pc=%h ins=%h v=%0b want pc=%h ins=%h v=1", i, ifpc0, ifins0, val0, i * 4, mem[i]);
         end
      end
      checks++; if (cnt0 !== 32'd3) begin fails++; $display("FAIL seq_count got %0d want 3", cnt0); end
   endtask

   task automatic test_stall();
      rst = 1; tick(); rst = 0;
      tick(); tick();
      stall = 1; #1;
      checks++; if (rd0 !== 1'b0) begin fails++; $display("FAIL stall_rd_en got %0b want 0", rd0); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({ifpc0, ifins0, val0, addr0, cnt0} !== {32'h4, mem[1], 1'b1, 32'h2, 32'd2}) begin
            fails++; $display("FAIL stall_hold%0d got pc=%h ins=%h v=%0b addr=%h cnt=%0d want pc=4 addr=2 cnt=2", i, ifpc0, ifins0, val0, addr0, cnt0);
         end
      end
      stall = 0;
      tick();
      checks++; if ({ifpc0, ifins0, val0, cnt0} !== {32'h8, mem[2], 1'b1, 32'd3}) begin
         fails++; $display("FAIL stall_release got pc=%h ins=%h v=%0b cnt=%0d want pc=8 cnt=3", ifpc0, ifins0, val0, cnt0);
      end
   endtask

   task automatic test_redirect_stall();
      stall = 1; rv = 1; rpc = 32'h40;
      tick();
      checks++; if ({val0, ifins0, cnt0} !== {1'b0, NOP, 32'd3}) begin
         fails++; $display("FAIL redir_flush got v=%0b ins=%h cnt=%0d want v=0 ins=%h cnt=3", val0, ifins0, cnt0, NOP);
      end
      stall = 0; rv = 0;
      tick();
      checks++; if ({ifpc0, ifins0, val0, cnt0} !== {32'h40, mem[16], 1'b1, 32'd4}) begin
         fails++; $display("FAIL redir_target got pc=%h ins=%h v=%0b cnt=%0d want pc=40 cnt=4", ifpc0, ifins0, val0, cnt0);
      end
   endtask

   task automatic test_fault();
      rv = 1; rpc = 32'h42;
      tick(); rv = 0; #1;
      checks++; if ({flt0, val0, rd0} !== 3'b100) begin
         fails++; $display("FAIL misalign got flt=%0b v=%0b rd=%0b want 1 0 0", flt0, val0, rd0);
      end
      tick();
      checks++; if ({val0, rd0, cnt0} !== {2'b00, 32'd4}) begin
         fails++; $display("FAIL fault_hold got v=%0b rd=%0b cnt=%0d want 0 0 4", val0, rd0, cnt0);
      end
      rv = 1; rpc = 32'h10;
      tick(); rv = 0;
      tick();
      checks++; if ({ifpc0, ifins0, val0, flt0, cnt0} !== {32'h10, mem[4], 2'b11, 32'd5}) begin
         fails++; $display("FAIL fault_resume got pc=%h ins=%h v=%0b flt=%0b cnt=%0d want pc=10 v=1 flt=1 cnt=5", ifpc0, ifins0, val0, flt0, cnt0);
      end
      rv = 1; rpc = 32'h1000;
      tick(); rv = 0; #1;
      checks++; if ({rd0, addr0} !== {1'b0, 32'h400}) begin
         fails++; $display("FAIL range_redirect got rd=%0b addr=%h want 0 400", rd0, addr0);
      end
      rv = 1; rpc = 32'hFFC;
      tick(); rv = 0;
      tick();
      checks++; if ({ifpc0, ifins0, val0, rd0, cnt0} !== {32'hFFC, mem[1023], 2'b10, 32'd6}) begin
         fails++; $display("FAIL last_word got pc=%h ins=%h v=%0b rd=%0b cnt=%0d want pc=ffc v=1 rd=0 cnt=6", ifpc0, ifins0, val0, rd0, cnt0);
      end
      tick();
      checks++; if ({val0, cnt0} !== {1'b0, 32'd6}) begin
         fails++; $display("FAIL past_end got v=%0b cnt=%0d want 0 6", val0, cnt0);
      end
   endtask

   task automatic test_small_depth();
      rst1 = 1; tick(); rst1 = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({ifpc1, ifins1, val1, flt1} !== {32'(i * 4), mem[i], 1'b1, i == 3}) begin
            fails++; $display("FAIL depth4_word%0d got pc=%h ins=%h v=%0b flt=%0b want pc=%h v=1 flt=%0b", i, ifpc1, ifins1, val1, flt1, i * 4, i == 3);
         end
      end
      tick(); tick();
      checks++; if ({val1, rd1, flt1, cnt1} !== {3'b001, 32'd4}) begin
         fails++; $display("FAIL depth4_stop got v=%0b rd=%0b flt=%0b cnt=%0d want 0 0 1 4", val1, rd1, flt1, cnt1);
      end
   endtask

   task automatic test_reset_mid_run();
      rv = 1; rpc = 32'h20;
      tick(); rv = 0;
      stall = 1; rst = 1;
      tick();
      checks++; if ({val0, addr0, cnt0, flt0, ifpc0, ifins0} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0, NOP}) begin
         fails++; $display("FAIL mid_reset got v=%0b addr=%h cnt=%0d flt=%0b pc=%h ins=%h want all reset", val0, addr0, cnt0, flt0, ifpc0, ifins0);
      end
      rst = 0; stall = 0;
   endtask

   task automatic test_random();
      model_t m;
      logic   exp_rd;
      rst = 1; stall = 0; rv = 0; rpc = 0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         m = step(m, rst, stall, rv, rpc);
         #1;
         exp_rd = !rst && !stall && !m.inf;
         checks++;
         if ({ifpc0, ifins0, val0, flt0, cnt0, addr0, rd0} !== {m.ipc, m.iins, m.ival, m.flt, m.cnt, m.pc >> 2, exp_rd}) begin
            fails++;
            $display("FAIL random_c%0d got pc=%h ins=%h v=%0b f=%0b n=%0d a=%h rd=%0b want pc=%h ins=%h v=%0b f=%0b n=%0d a=%h rd=%0b",
                     c, ifpc0, ifins0, val0, flt0, cnt0, addr0, rd0, m.ipc, m.iins, m.ival, m.flt, m.cnt, m.pc >> 2, exp_rd);
         end
         rst   = ($urandom_range(0, 59) == 0);
         stall = ($urandom_range(0, 3) == 0);
         rv    = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 4))
            0: rpc = 32'($urandom_range(0, 1023)) << 2;
            1: rpc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            2: rpc = ($urandom & 32'hFFFF_F000) | 32'h1000;
            3: rpc = $urandom_range(0, 1) ? 32'hFF8 : 32'hFFC;
            default: rpc = 32'h0;
         endcase
      end
   endtask

   initial begin
      rst = 1; rst1 = 1; stall = 0; rv = 0; rpc = 0;
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      for (int i = 3; i < 1024; i++) mem[i] = $urandom;
      test_reset();
      test_stall();
      test_redirect_stall();
      test_fault();
      test_small_depth();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RISC-V core, directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word address and read enable.
- Captures the returned instruction into the IF/ID pipeline register, with its PC and a valid bit, for the decoder.
- Handles stall, redirect (branch/jump/trap) with flush, and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset.
- IMEM_DEPTH, 1024: instruction memory size in 32-bit words. Word indices at or above this are out of range.
- NOP_INSTR, 32'h0000_0013: instruction (addi x0,x0,0) presented on IF/ID when not valid.

Ports:
- clk  in  1: core clock. All state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- stall  in  1: hazard-unit stall. Holds PC and IF/ID.
- redirect_valid  in  1: branch/jump/trap redirect from EX.
- redirect_pc  in  32: redirect byte address.
- imem_addr  out  32: word index to instruction memory, = pc >> 2 (combinational from pc).
- imem_rd_en  out  1: instruction memory read enable.
- imem_instr  in  32: instruction from memory. Sampled by memory on the falling edge, stable at the next rising edge.
- if_id_pc  out  32: byte PC of the IF/ID instruction.
- if_id_instr  out  32: IF/ID instruction.
- if_id_valid  out  1: IF/ID holds a real instruction.
- fetch_fault  out  1: sticky out-of-range or misaligned fetch flag.
- fetch_count  out  32: number of instructions delivered valid (wraps).

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc=RESET_PC, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_fault=0, fetch_count=0, state=RUN.
  - Reset overrides every other input.
- Memory interface:
  - imem_addr = {2'b00, pc[31:2]}.
  - imem_rd_en = (state==RUN) & ~stall & ~rst.
- Latency: pc set at rising edge N, memory read at the falling edge inside cycle N, instruction visible on IF/ID after rising edge N+1. The first valid instruction appears at the first rising edge with rst=0.
- FSM states RUN and FAULT. Per rising edge, in priority order:
  1. rst: reset as above.
  2. redirect_valid (wins over stall, any state):
     - if_id_valid<=0, if_id_instr<=NOP_INSTR (flush).
     - If redirect_pc[1:0]!=0 or redirect_pc[31:2]>=IMEM_DEPTH: state<=FAULT, fetch_fault<=1, pc<=redirect_pc.
     - Otherwise: pc<=redirect_pc, state<=RUN. fetch_fault stays at its previous value (sticky until rst).
  3. state==FAULT: pc, IF/ID hold with if_id_valid=0. No memory reads.
  4. stall: pc, if_id_pc, if_id_instr, if_id_valid all hold.
  5. RUN, no stall:
     - if_id_pc<=pc, if_id_instr<=imem_instr, if_id_valid<=1, fetch_count<=fetch_count+1.
     - pc<=pc+4 (32-bit wrap).
     - If (pc+4)[31:2]>=IMEM_DEPTH: state<=FAULT, fetch_fault<=1. The instruction at the last in-range word is still delivered.
- Stall and redirect on the same edge: redirect wins. No stalled instruction survives.
- Stall release: the held pc is re-read (rd_en high again). The instruction is captured on the first unstalled edge; no duplicate, no skip.
- fetch_count does not increment on flush, stall, fault, or reset cycles.

Decomposition:
- core_pkg: NOP_INSTR, RESET_PC default, IMEM_DEPTH, typedef fetch_state_t {RUN, FAULT}, typedef if_id_t struct {pc, instr, valid}.
- Sub-module pc_gen: next-PC mux (reset / redirect / hold / +4) plus range and alignment check, producing next_pc and fault_next.
- The top level holds the IF/ID register, FSM, and counter.

Test Plan:
1. Reset release, RESET_PC=0, memory preloaded with 0x00000013, 0x00100093, 0x00200113:
   - if_id_valid=0 during reset.
   - Then, on successive edges, if_id_pc=0,4,8 with the matching instructions.
   - fetch_count=3.
2. stall high for 3 cycles while if_id_pc=4:
   - IF/ID and pc hold, imem_rd_en=0.
   - After release, next edge gives if_id_pc=8 with no duplicate of 4.
3. redirect_valid with redirect_pc=0x40 and stall=1 on the same edge:
   - if_id_valid=0 next cycle.
   - The following edge gives if_id_pc=0x40, valid=1.
4. redirect_pc=0x42 (misaligned):
   - fetch_fault=1, if_id_valid stays 0, imem_rd_en=0.
   - A later redirect to 0x10 resumes fetch at 0x10 with fetch_fault still 1.
5. IMEM_DEPTH=4, sequential fetch from 0:
   - Words 0..3 delivered (pc 0x0..0xC).
   - Then fetch_fault=1 and no further valid instructions.
6. rst asserted mid-run at pc=0x20 with stall=1:
   - Next edge: pc=RESET_PC, if_id_valid=0, fetch_count=0, fetch_fault=0.
